// File: rtl/uart_dec_line_sched.sv
// uart_dec_line_sched: round-robin scheduler that converts 12-bit requester
// values to 4 decimal ASCII digits and streams each line to one shared UART.
module uart_dec_line_sched #(
    parameter int NREQ      = 4,
    parameter int PREFIX_EN = 0,
    parameter int CRLF      = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [12*NREQ-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic                 busy,
    output logic                 done,
    output logic [2:0]           done_id,
    output logic [7:0]           tx_data,
    output logic                 tx_en,
    input  logic                 tx_end
);

    // Line length: optional "<idx>:" prefix, 4 digits, LF or CR LF.
    localparam int         LEN  = 4 + ((PREFIX_EN != 0) ? 2 : 0) + ((CRLF != 0) ? 2 : 1);
    localparam logic [2:0] LAST = 3'(LEN - 1);

    typedef enum logic [2:0] {S_IDLE, S_CONV, S_LOAD, S_SEND, S_WAIT} state_t;

    state_t          r_state;
    state_t          w_next;
    logic [2:0]      r_ptr;
    logic [2:0]      r_gid;
    logic [2:0]      r_bcnt;
    logic [3:0]      r_step;
    logic [11:0]     r_bin;
    logic [15:0]     r_bcd;
    logic [7:0]      r_tx_data;

    logic [NREQ-1:0] w_rot;
    logic            w_grant;
    logic [2:0]      w_gidx;
    logic [11:0]     w_gdata;
    logic            w_take;

    // One double-dabble step: add 3 to every nibble >= 5, then shift in the next binary bit.
    function automatic logic [15:0] dd_step(input logic [15:0] bcd, input logic in_bit);
        logic [15:0] a;
        for (int i = 0; i < 4; i++)
            a[4*i +: 4] = (bcd[4*i +: 4] >= 4'd5) ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
        return 16'({a, in_bit});
    endfunction

    // ASCII byte at position pos of the current line.
    function automatic logic [7:0] line_byte(input logic [2:0] pos, input logic [2:0] gid,
                                             input logic [15:0] bcd);
        logic [3:0] p;
        p = {1'b0, pos};
        if (PREFIX_EN != 0) begin
            if (p == 4'd0) return 8'h30 + {5'd0, gid};
            if (p == 4'd1) return 8'h3A;
            p = p - 4'd2;
        end
        case (p)
            4'd0:    return {4'h3, bcd[15:12]};
            4'd1:    return {4'h3, bcd[11:8]};
            4'd2:    return {4'h3, bcd[7:4]};
            4'd3:    return {4'h3, bcd[3:0]};
            4'd4:    return (CRLF != 0) ? 8'h0D : 8'h0A;
            default: return 8'h0A;
        endcase
    endfunction

    // Round-robin pick: first requesting index at or after the pointer, wrapping.
    always_comb begin
        w_rot   = NREQ'({req_valid, req_valid} >> r_ptr);
        w_grant = 1'b0;
        w_gidx  = 3'd0;
        w_gdata = 12'd0;
        for (int j = NREQ - 1; j >= 0; j--) begin
            if (w_rot[j]) begin
                w_grant = 1'b1;
                w_gidx  = 3'((int'(r_ptr) + j) % NREQ);
            end
        end
        for (int j = 0; j < NREQ; j++) begin
            if (3'(j) == w_gidx) w_gdata = req_data[12*j +: 12];
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next-state and handshake outputs.
    always_comb begin
        w_next    = r_state;
        w_take    = 1'b0;
        req_ready = '0;
        busy      = 1'b0;
        done      = 1'b0;
        tx_en     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_grant) begin
                    w_take    = 1'b1;
                    req_ready = {{(NREQ-1){1'b0}}, 1'b1} << w_gidx;
                    busy      = 1'b1;
                    w_next    = S_CONV;
                end
            end
            S_CONV: begin
                busy = 1'b1;
                if (r_step == 4'd11) w_next = S_LOAD;
            end
            S_LOAD: begin
                busy   = 1'b1;
                w_next = S_SEND;
            end
            S_SEND: begin
                busy   = 1'b1;
                tx_en  = 1'b1;
                w_next = S_WAIT;
            end
            S_WAIT: begin
                busy = 1'b1;
                if (tx_end) begin
                    if (r_bcnt == LAST) begin
                        done   = 1'b1;
                        busy   = 1'b0;
                        w_next = S_IDLE;
                    end else begin
                        w_next = S_SEND;
                    end
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Control registers: pointer, granted id, conversion step, byte counter, UART byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr     <= 3'd0;
            r_gid     <= 3'd0;
            r_bcnt    <= 3'd0;
            r_step    <= 4'd0;
            r_tx_data <= 8'd0;
        end else begin
            case (r_state)
                S_IDLE: if (w_take) begin
                    r_gid  <= w_gidx;
                    r_ptr  <= (w_gidx == 3'(NREQ - 1)) ? 3'd0 : w_gidx + 3'd1;
                    r_step <= 4'd0;
                end
                S_CONV: r_step <= r_step + 4'd1;
                S_LOAD: begin
                    r_bcnt    <= 3'd0;
                    r_tx_data <= line_byte(3'd0, r_gid, r_bcd);
                end
                S_WAIT: if (tx_end && r_bcnt != LAST) begin
                    r_bcnt    <= r_bcnt + 3'd1;
                    r_tx_data <= line_byte(r_bcnt + 3'd1, r_gid, r_bcd);
                end
                default: ;
            endcase
        end
    end

    // Conversion datapath: capture value at grant, one double-dabble step per CONV cycle.
    always_ff @(posedge clk) begin
        if (r_state == S_IDLE && w_take) begin
            r_bin <= w_gdata;
            r_bcd <= 16'd0;
        end else if (r_state == S_CONV) begin
            r_bcd <= dd_step(r_bcd, r_bin[11]);
            r_bin <= {r_bin[10:0], 1'b0};
        end
    end

    assign done_id = r_gid;
    assign tx_data = r_tx_data;

endmodule

// File: tb/tb_uart_dec_line_sched.sv
// Bench for uart_dec_line_sched: default instance (A) and a prefix+CRLF instance (B),
// expected line bytes queued from a decimal model and popped on each tx_en.
module tb_uart_dec_line_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        sel = 1'b0;
    logic        tx_end = 1'b0;
    logic [3:0]  req_valid = 4'd0;
    logic [47:0] req_data = 48'd0;

    logic [3:0] a_req_valid, b_req_valid, a_req_ready, b_req_ready;
    logic       a_tx_end, b_tx_end, a_busy, b_busy, a_done, b_done, a_tx_en, b_tx_en;
    logic [2:0] a_done_id, b_done_id;
    logic [7:0] a_tx_data, b_tx_data;

    logic [3:0] w_req_ready;
    logic       w_busy, w_done, w_tx_en;
    logic [2:0] w_done_id;
    logic [7:0] w_tx_data;

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    assign a_req_valid = sel ? 4'd0 : req_valid;
    assign b_req_valid = sel ? req_valid : 4'd0;
    assign a_tx_end    = sel ? 1'b0 : tx_end;
    assign b_tx_end    = sel ? tx_end : 1'b0;
    assign w_req_ready = sel ? b_req_ready : a_req_ready;
    assign w_busy      = sel ? b_busy : a_busy;
    assign w_done      = sel ? b_done : a_done;
    assign w_done_id   = sel ? b_done_id : a_done_id;
    assign w_tx_data   = sel ? b_tx_data : a_tx_data;
    assign w_tx_en     = sel ? b_tx_en : a_tx_en;

    uart_dec_line_sched #(.NREQ(4), .PREFIX_EN(0), .CRLF(0)) u_a (
        .clk(clk), .rst(rst), .req_valid(a_req_valid), .req_data(req_data),
        .req_ready(a_req_ready), .busy(a_busy), .done(a_done), .done_id(a_done_id),
        .tx_data(a_tx_data), .tx_en(a_tx_en), .tx_end(a_tx_end));

    uart_dec_line_sched #(.NREQ(4), .PREFIX_EN(1), .CRLF(1)) u_b (
        .clk(clk), .rst(rst), .req_valid(b_req_valid), .req_data(req_data),
        .req_ready(b_req_ready), .busy(b_busy), .done(b_done), .done_id(b_done_id),
        .tx_data(b_tx_data), .tx_en(b_tx_en), .tx_end(b_tx_end));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void push_line(input int v, input int id, input bit pre, input bit crlf);
        if (pre) begin
            exp_q.push_back(8'(48 + id));
            exp_q.push_back(8'h3A);
        end
        exp_q.push_back(8'(48 + v / 1000));
        exp_q.push_back(8'(48 + (v / 100) % 10));
        exp_q.push_back(8'(48 + (v / 10) % 10));
        exp_q.push_back(8'(48 + v % 10));
        if (crlf) exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endfunction

    task automatic reset_dut();
        @(posedge clk); #1;
        rst = 1'b1; req_valid = 4'd0; tx_end = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic grant(input logic [3:0] m, input bit clr);
        #1;
        chk("req_ready", w_req_ready, m);
        chk("busy_at_grant", w_busy, 1);
        @(posedge clk); #1;
        if (clr) req_valid = req_valid & ~m;
    endtask

    task automatic serve(input int len, input int count, input int gap,
                         input logic [2:0] id, input bit stray);
        int n;
        logic [7:0] d, e;
        for (int b = 0; b < count; b++) begin
            n = 0;
            do begin @(negedge clk); #1; n++; end while (!w_tx_en && n < 40);
            if (!w_tx_en) begin
                chk("tx_en_timeout", w_tx_en, 1);
                return;
            end
            if (b == 0) chk("first_tx_en_latency", n, 14);
            else        chk("next_tx_en_latency", n, 1);
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hFF;
            chk("tx_byte", w_tx_data, e);
            d = w_tx_data;
            if (stray && b == 1) begin
                tx_end = 1'b1;
                @(posedge clk); #1;
                tx_end = 1'b0;
            end
            for (int g = 0; g < gap; g++) begin
                @(negedge clk); #1;
                chk("tx_data_hold", w_tx_data, d);
                chk("tx_en_single", w_tx_en, 0);
            end
            tx_end = 1'b1;
            #1;
            chk("done_flag", w_done, (b == len - 1));
            if (b == len - 1) begin
                chk("done_id", w_done_id, id);
                chk("busy_after_last", w_busy, 0);
            end else begin
                chk("busy_mid_line", w_busy, 1);
            end
            @(posedge clk); #1;
            tx_end = 1'b0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=still_running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        logic [7:0] e;

        // Reset state
        reset_dut();
        chk("rst_req_ready", w_req_ready, 0);
        chk("rst_busy", w_busy, 0);
        chk("rst_done", w_done, 0);
        chk("rst_done_id", w_done_id, 0);
        chk("rst_tx_data", w_tx_data, 0);
        chk("rst_tx_en", w_tx_en, 0);

        // Nominal line 1543
        req_data[11:0] = 12'd1543;
        req_valid = 4'b0001;
        push_line(1543, 0, 0, 0);
        grant(4'b0001, 1);
        serve(5, 5, 3, 3'd0, 0);

        // Zero value, with a stray tx_end in the tx_en cycle of byte 1
        req_data[11:0] = 12'd0;
        req_valid = 4'b0001;
        push_line(0, 0, 0, 0);
        grant(4'b0001, 1);
        serve(5, 5, 1, 3'd0, 1);

        // Max value
        req_data[11:0] = 12'd4095;
        req_valid = 4'b0001;
        push_line(4095, 0, 0, 0);
        grant(4'b0001, 1);
        serve(5, 5, 2, 3'd0, 0);

        // Arbitration: req1 and req2 together, served back to back
        reset_dut();
        req_data[23:12] = 12'd12;
        req_data[35:24] = 12'd900;
        req_valid = 4'b0110;
        push_line(12, 1, 0, 0);
        push_line(900, 2, 0, 0);
        grant(4'b0010, 1);
        serve(5, 5, 1, 3'd1, 0);
        grant(4'b0100, 1);
        serve(5, 5, 1, 3'd2, 0);

        // Reset while waiting on byte 3
        reset_dut();
        req_data[11:0] = 12'd1234;
        req_valid = 4'b0001;
        push_line(1234, 0, 0, 0);
        grant(4'b0001, 1);
        serve(5, 3, 2, 3'd0, 0);
        n = 0;
        do begin @(negedge clk); #1; n++; end while (!w_tx_en && n < 40);
        chk("byte3_tx_en", w_tx_en, 1);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hFF;
        chk("byte3_data", w_tx_data, e);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_busy", w_busy, 0);
        chk("midrst_done", w_done, 0);
        chk("midrst_tx_en", w_tx_en, 0);
        chk("midrst_tx_data", w_tx_data, 0);
        chk("midrst_req_ready", w_req_ready, 0);
        tx_end = 1'b1;
        #1;
        chk("late_tx_end_no_done", w_done, 0);
        @(posedge clk); #1;
        tx_end = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            chk("late_tx_end_no_tx_en", w_tx_en, 0);
        end
        exp_q.delete();

        // Fairness: pointer back at 0, all four held high
        @(posedge clk); #1;
        req_data = {12'd4, 12'd3, 12'd2, 12'd1};
        req_valid = 4'b1111;
        for (int r = 0; r < 5; r++) begin
            push_line((r % 4) + 1, r % 4, 0, 0);
            grant(4'b0001 << (r % 4), 0);
            serve(5, 5, 1, 3'(r % 4), 0);
        end
        req_valid = 4'd0;

        // Prefix and CRLF instance: req2 = 7
        sel = 1'b1;
        reset_dut();
        req_data[35:24] = 12'd7;
        req_valid = 4'b0100;
        push_line(7, 2, 1, 1);
        grant(4'b0100, 1);
        serve(8, 8, 2, 3'd2, 0);
        chk("queue_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
